// File: rtl/ctrl_fsm_gen2_pkg.sv
// ctrl_pkg: shared opcode constants, FSM state type, datapath select codes
// and the EXEC-cycle strobe decoder for the ctrl_fsm_gen2 sequencer.
// Optional feature macro: CTRL_IRQ_EN (adds the IRQ state).
`timescale 1ns/1ps
package ctrl_pkg;

  // Instruction opcodes
  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_MOVR  = 4'b0100;
  localparam logic [3:0] OP_MOVA  = 4'b0101;
  localparam logic [3:0] OP_JZRS  = 4'b0110;
  localparam logic [3:0] OP_JZIMM = 4'b0111;
  localparam logic [3:0] OP_JCRS  = 4'b1000;
  localparam logic [3:0] OP_ILL9  = 4'b1001;
  localparam logic [3:0] OP_JCIMM = 4'b1010;
  localparam logic [3:0] OP_SHL   = 4'b1011;
  localparam logic [3:0] OP_SHR   = 4'b1100;
  localparam logic [3:0] OP_LDIMM = 4'b1101;
  localparam logic [3:0] OP_ILLE  = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // ALU operation selects
  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_MOVA = 4'b0010;
  localparam logic [3:0] ALU_SHL  = 4'b0001;
  localparam logic [3:0] ALU_SHR  = 4'b0011;

  // Accumulator source selects
  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b10;
  localparam logic [1:0] ACC_IMM = 2'b11;

  // PC source selects
  localparam logic [1:0] PC_IMM = 2'b00;
  localparam logic [1:0] PC_REG = 2'b01;
  localparam logic [1:0] PC_IRQ = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3
`ifdef CTRL_IRQ_EN
    , ST_IRQ  = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic       load_ir;
    logic       inc_pc;
    logic       load_pc;
    logic       load_reg;
    logic       load_acc;
    logic [1:0] sel_pc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
    logic       illegal;
  } strobe_t;

  // Datapath strobes for the EXEC cycle of a latched opcode. Jumps look at
  // the live flags; a taken jump loads the PC instead of incrementing it.
  function automatic strobe_t exec_decode(logic [3:0] op, logic z1, logic c1);
    strobe_t s;
    s = '0;
    case (op)
      OP_NOP:   s.inc_pc = 1'b1;
      OP_ADD:   begin s.sel_alu = ALU_ADD;  s.sel_acc = ACC_ALU; s.load_acc = 1'b1; s.inc_pc = 1'b1; end
      OP_SUB:   begin s.sel_alu = ALU_SUB;  s.sel_acc = ACC_ALU; s.load_acc = 1'b1; s.inc_pc = 1'b1; end
      OP_SHL:   begin s.sel_alu = ALU_SHL;  s.sel_acc = ACC_ALU; s.load_acc = 1'b1; s.inc_pc = 1'b1; end
      OP_SHR:   begin s.sel_alu = ALU_SHR;  s.sel_acc = ACC_ALU; s.load_acc = 1'b1; s.inc_pc = 1'b1; end
      OP_NOR:   begin s.sel_alu = ALU_NOR;  s.sel_acc = ACC_REG; s.load_acc = 1'b1; s.inc_pc = 1'b1; end
      OP_MOVR:  begin s.sel_alu = ALU_PASS; s.sel_acc = ACC_REG; s.load_acc = 1'b1; s.inc_pc = 1'b1; end
      OP_MOVA:  begin s.sel_alu = ALU_MOVA; s.load_reg = 1'b1; s.inc_pc = 1'b1; end
      OP_LDIMM: begin s.sel_acc = ACC_IMM;  s.load_acc = 1'b1; s.inc_pc = 1'b1; end
      OP_JZRS:  if (z1) begin s.load_pc = 1'b1; s.sel_pc = PC_REG; end else begin s.inc_pc = 1'b1; end
      OP_JZIMM: if (z1) begin s.load_pc = 1'b1; s.sel_pc = PC_IMM; end else begin s.inc_pc = 1'b1; end
      OP_JCRS:  if (c1) begin s.load_pc = 1'b1; s.sel_pc = PC_REG; end else begin s.inc_pc = 1'b1; end
      OP_JCIMM: if (c1) begin s.load_pc = 1'b1; s.sel_pc = PC_IMM; end else begin s.inc_pc = 1'b1; end
      OP_HALT:  s = '0;
      OP_ILL9, OP_ILLE: begin s.illegal = 1'b1; s.inc_pc = 1'b1; end
      default:  begin s.illegal = 1'b1; s.inc_pc = 1'b1; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_fsm_gen2_if.sv
// Sequencer <-> datapath bundle: IR opcode, ALU flags, fetch handshake,
// datapath strobes/selects and status. Optional macro: CTRL_IRQ_EN adds irq/irq_ack.
`timescale 1ns/1ps
interface ctrl_fsm_gen2_if;
  logic [3:0] Opcode;
  logic       z1;
  logic       c1;
  logic       instr_valid;
  logic       run;
  logic       LoadIR;
  logic       IncPC;
  logic       LoadPC;
  logic       LoadReg;
  logic       LoadAcc;
  logic [1:0] SelPC;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic       halted;
  logic       busy;
  logic       illegal;
  logic       fetch_err;
`ifdef CTRL_IRQ_EN
  logic       irq;
  logic       irq_ack;
`endif

  modport master (
    input  Opcode, z1, c1, instr_valid, run,
    output LoadIR, IncPC, LoadPC, LoadReg, LoadAcc, SelPC, SelAcc, SelALU,
    output halted, busy, illegal, fetch_err
`ifdef CTRL_IRQ_EN
    , input irq, output irq_ack
`endif
  );

  modport slave (
    output Opcode, z1, c1, instr_valid, run,
    input  LoadIR, IncPC, LoadPC, LoadReg, LoadAcc, SelPC, SelAcc, SelALU,
    input  halted, busy, illegal, fetch_err
`ifdef CTRL_IRQ_EN
    , output irq, input irq_ack
`endif
  );
endinterface

// File: rtl/ctrl_fsm_gen2_fetch_timer.sv
// ctrl_fetch_timer: counts FETCH cycles spent waiting for instr_valid and
// flags expiry on the cycle that reaches FETCH_TIMEOUT. FETCH_TIMEOUT=0 disables it.
`timescale 1ns/1ps
module ctrl_fetch_timer #(
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic expired
);
  localparam bit             TIMER_ON = (FETCH_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(FETCH_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next count: clear wins, otherwise step on each idle FETCH cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && TIMER_ON) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Expiry fires on the idle cycle that completes FETCH_TIMEOUT waits
  always_comb begin
    expired = TIMER_ON && count_en && !clear && (cnt_q == LIMIT_M1);
  end
endmodule

// File: rtl/ctrl_fsm_gen2.sv
// ctrl_fsm_gen2: FETCH/DECODE/EXEC/HALT instruction sequencer with fetch
// timeout. Optional macro: CTRL_IRQ_EN adds a one-cycle IRQ vectoring state.
`timescale 1ns/1ps
module ctrl_fsm_gen2
  import ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 4
) (
  input  logic            CLK,
  input  logic            CLB,
  ctrl_fsm_gen2_if.master bus
);
  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       fetch_err_q, fetch_err_d;
  logic       tmr_expired_s;
  strobe_t    ctl_s;
  logic       halted_s;
  logic       busy_s;
`ifdef CTRL_IRQ_EN
  logic       irq_ack_s;
`endif

  ctrl_fetch_timer #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_fetch_timer (
    .clk      (CLK),
    .rst_n    (CLB),
    .count_en ((state_q == ST_FETCH) && !bus.instr_valid),
    .clear    (state_q != ST_FETCH),
    .expired  (tmr_expired_s)
  );

  // State, latched opcode and sticky fetch error
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state_q     <= ST_FETCH;
      op_q        <= 4'b0000;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state selection; irq outranks the HALT opcode and run
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.instr_valid) begin
          state_d = ST_DECODE;
        end else if (tmr_expired_s) begin
          state_d     = ST_HALT;
          fetch_err_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        op_d    = bus.Opcode;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
`ifdef CTRL_IRQ_EN
        if (bus.irq) begin
          state_d = ST_IRQ;
        end else
`endif
        if (op_q == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
`ifdef CTRL_IRQ_EN
        if (bus.irq) begin
          state_d = ST_IRQ;
        end else
`endif
        if (bus.run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
`ifdef CTRL_IRQ_EN
      ST_IRQ:  state_d = ST_FETCH;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes and status decoded from the current state. LoadIR is gated by
  // CLB so nothing toggles while reset is held.
  always_comb begin
    ctl_s    = '0;
    halted_s = 1'b0;
    busy_s   = 1'b0;
`ifdef CTRL_IRQ_EN
    irq_ack_s = 1'b0;
`endif
    case (state_q)
      ST_FETCH:  ctl_s.load_ir = bus.instr_valid & CLB;
      ST_DECODE: busy_s = 1'b1;
      ST_EXEC: begin
        ctl_s  = exec_decode(op_q, bus.z1, bus.c1);
        busy_s = 1'b1;
      end
      ST_HALT:   halted_s = 1'b1;
`ifdef CTRL_IRQ_EN
      ST_IRQ: begin
        ctl_s.load_pc = 1'b1;
        ctl_s.sel_pc  = PC_IRQ;
        busy_s        = 1'b1;
        irq_ack_s     = 1'b1;
      end
`endif
      default:   ctl_s = '0;
    endcase
  end

  assign bus.LoadIR    = ctl_s.load_ir;
  assign bus.IncPC     = ctl_s.inc_pc;
  assign bus.LoadPC    = ctl_s.load_pc;
  assign bus.LoadReg   = ctl_s.load_reg;
  assign bus.LoadAcc   = ctl_s.load_acc;
  assign bus.SelPC     = ctl_s.sel_pc;
  assign bus.SelAcc    = ctl_s.sel_acc;
  assign bus.SelALU    = ctl_s.sel_alu;
  assign bus.illegal   = ctl_s.illegal;
  assign bus.halted    = halted_s;
  assign bus.busy      = busy_s;
  assign bus.fetch_err = fetch_err_q;
`ifdef CTRL_IRQ_EN
  assign bus.irq_ack   = irq_ack_s;
`endif
endmodule

// File: doc/ctrl_fsm_gen2.md
CTRL_FSM_GEN2 -- requirements
Module: ctrl_fsm_gen2

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 15: max FETCH cycles without instr_valid before fault; 0 disables timeout.
REQ-002 Parameter CNT_W, default 4: timeout counter width; SHALL satisfy 2**CNT_W > FETCH_TIMEOUT.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 CLB  in  1  reset, asynchronous, active-low.
REQ-005 Opcode  in  4  instruction opcode from IR.
REQ-006 z1, c1  in  1 each  ALU zero/carry flags.
REQ-007 instr_valid  in  1  instruction memory has valid word on IR input.
REQ-008 run  in  1  resume pulse from HALT.
REQ-009 irq  in  1  interrupt request, level (present only with CTRL_IRQ_EN).
REQ-010 LoadIR, IncPC, LoadPC, LoadReg, LoadAcc  out  1 each  datapath strobes.
REQ-011 SelPC  out  2  PC source: 00 immediate, 01 register, 10 IRQ vector.
REQ-012 SelAcc  out  2  Acc source: 00 ALU, 10 register, 11 immediate.
REQ-013 SelALU  out  4  ALU op select.
REQ-014 halted, busy, illegal, fetch_err  out  1 each  status; irq_ack  out  1 (CTRL_IRQ_EN only).

Function
REQ-015 States SHALL be FETCH, DECODE, EXEC, HALT, IRQ (IRQ only with CTRL_IRQ_EN).
REQ-016 FETCH: LoadIR=instr_valid; instr_valid=1 -> DECODE next cycle; else stay.
REQ-017 DECODE: one cycle, latch Opcode into internal op register, all strobes 0, -> EXEC.
REQ-018 EXEC: one cycle, strobes per REQ-019..REQ-023 from latched op, -> FETCH (or HALT/IRQ).
REQ-019 Opcode map: 0000 NOP, 0001 ADD, 0010 SUB, 0011 NOR, 0100 MOVR, 0101 MOVA, 0110 JZrs, 0111 JZimm, 1000 JCrs, 1010 JCimm, 1011 SHL, 1100 SHR, 1101 LDimm, 1111 HALT.
REQ-020 ALU ops: ADD SelALU=1000, SUB 1100, SHL 0001, SHR 0011, all SelAcc=00 LoadAcc=1 IncPC=1; NOR SelALU=0100 SelAcc=10 LoadAcc=1 IncPC=1; MOVR SelALU=0000 SelAcc=10 LoadAcc=1 IncPC=1.
REQ-021 MOVA: SelALU=0010, LoadReg=1, IncPC=1; LDimm: SelAcc=11, LoadAcc=1, IncPC=1; NOP: IncPC=1 only.
REQ-022 Jumps: flag (z1 for JZ*, c1 for JC*) sampled in EXEC; taken -> LoadPC=1, IncPC=0, SelPC=01 (rs) or 00 (imm); not taken -> IncPC=1 only.
REQ-023 HALT opcode: EXEC strobes all 0, -> HALT.
REQ-024 Opcodes 1001, 1110: illegal=1 for the EXEC cycle, executed as NOP.
REQ-025 IncPC and LoadPC SHALL never both be 1; every strobe not listed for a state is 0; SelALU/SelAcc/SelPC are 0 outside EXEC/IRQ.
REQ-026 Minimum instruction latency 3 cycles (FETCH with instr_valid, DECODE, EXEC).
REQ-027 Timeout counter clears on leaving FETCH, increments per FETCH cycle with instr_valid=0; reaching FETCH_TIMEOUT -> HALT and fetch_err=1 (sticky until reset).
REQ-028 HALT: all strobes 0, halted=1; run=1 -> FETCH next cycle; run ignored in other states.
REQ-029 busy=1 in DECODE, EXEC, IRQ; 0 in FETCH and HALT.

Reset
REQ-030 CLB low SHALL immediately force state FETCH, timeout counter 0, op register 0000, fetch_err 0, all outputs 0, including mid-instruction.
REQ-031 First fetch SHALL occur on the first rising CLK edge after CLB deasserts.

Configuration
REQ-032 Macro CTRL_IRQ_EN defined: irq sampled in EXEC and HALT; irq=1 -> IRQ state for one cycle with LoadPC=1, SelPC=10, irq_ack=1, then FETCH; irq has priority over HALT-opcode and run.
REQ-033 CTRL_IRQ_EN undefined: irq/irq_ack ports and IRQ state absent; SelPC=10 never produced.

Structure
REQ-034 Package ctrl_pkg SHALL hold opcode constants, state type, SelALU/SelAcc/SelPC codes.
REQ-035 Timeout counter SHALL be sub-module ctrl_fetch_timer (inputs count_en, clear; output expired).

Verification
REQ-036 Reset, instr_valid=1, Opcode=0001 -> LoadIR cycle 1, DECODE cycle 2, cycle 3 SelALU=1000 LoadAcc=1 IncPC=1.
REQ-037 JZimm with z1=1 -> EXEC LoadPC=1 SelPC=00 IncPC=0; repeat with z1=0 -> IncPC=1 LoadPC=0.
REQ-038 instr_valid held 0, FETCH_TIMEOUT=15 -> HALT after 15 FETCH cycles, fetch_err=1, halted=1; run pulse -> FETCH, fetch_err stays 1.
REQ-039 Opcode=1110 -> illegal=1 one cycle, IncPC=1, no other strobe.
REQ-040 CLB asserted during EXEC of LDimm -> LoadAcc drops to 0 without clock edge, state FETCH.
REQ-041 CTRL_IRQ_EN, irq=1 during EXEC of HALT opcode -> IRQ cycle (LoadPC=1, SelPC=10, irq_ack=1), then FETCH, halted stays 0.
